ldm_scan_rx: RTL and testbench
==============================

# ldm_scan_rx

Receive-side decoder for the LED dot-matrix (LDM) scan interface driven by the `fsm` scan generator. It samples `LDM_CLK`, `LDM_ADDR_EN` and `LDM_ADDR[3:0]` in its own clock domain, checks the row sequence, and reconstructs a one-hot row-select bus for the matrix driver. It also reports frame boundaries, a frame count, sequence errors and loss of link to the system controller and the test bench.

## Interface
- `ROWS`, 16: rows per frame; legal addresses are 0..ROWS-1; range 2..16.
- `TIMEOUT`, 1024: `clk` cycles without an `LDM_CLK` rising edge before link is declared lost; minimum 8.
- `clk`  in  1  receiver clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `LDM_CLK`  in  1  scan clock from the generator; asynchronous to `clk`.
- `LDM_ADDR_EN`  in  1  address-valid; low means blanking.
- `LDM_ADDR`  in  4  row address; stable around each `LDM_CLK` rising edge.
- `row_sel`  out  ROWS  one-hot active row; all-zero when blanked, idle or in resync.
- `row_valid`  out  1  high while `row_sel` is non-zero.
- `frame_start`  out  1  one-cycle pulse when address 0 is accepted.
- `frame_done`  out  1  one-cycle pulse when address ROWS-1 is accepted.
- `frame_cnt`  out  8  count of completed frames; wraps 255→0.
- `seq_err`  out  1  sticky sequence/range error; cleared only by `rst`.
- `link_lost`  out  1  high while in IDLE after a timeout.

## Operation
- **Input capture.** `LDM_CLK`, `LDM_ADDR_EN` and `LDM_ADDR` each pass through two flip-flops. A rising edge of `LDM_CLK` is detected from sync stage 2 against one further delay register. The enable and address values used on an edge are taken from their stage-2 registers.
- **States: IDLE, SYNC, RUN.** Reset enters SYNC.
  - **SYNC:** outputs blanked. An enabled edge with address 0 accepts row 0, pulses `frame_start`, sets `exp` = 1 and moves to RUN. Any other enabled edge is ignored.
  - **RUN:** an enabled edge with address == `exp` is accepted. `exp` advances as `exp+1`, with ROWS-1 wrapping to 0. An address different from `exp`, or any address ≥ ROWS, sets `seq_err`, blanks the outputs and moves to SYNC.
  - **Edge with `LDM_ADDR_EN` low:** blanks `row_sel`. The state and `exp` are unchanged.
  - **IDLE:** entered from any state when the timeout counter reaches TIMEOUT. Sets `link_lost` and blanks the outputs. The next `LDM_CLK` rising edge clears `link_lost` and moves to SYNC; that edge itself is not decoded.
- **Accepting address a:** `row_sel` is set to `1<<a` and `row_valid` = 1.
  - a = 0 pulses `frame_start`.
  - a = ROWS-1 pulses `frame_done` and increments `frame_cnt` (8-bit, modulo 256).
- **Timeout counter.** Width is clog2(TIMEOUT+1). It clears on every detected rising edge, otherwise increments and saturates at TIMEOUT.
- **Reset values:** state SYNC, `row_sel` 0, `row_valid` 0, `frame_start` 0, `frame_done` 0, `frame_cnt` 0, `seq_err` 0, `link_lost` 0, timeout counter 0, `exp` 0.

## Timing
- **Input requirements.** `LDM_CLK` high and low phases are each ≥ 3 `clk` periods. Address and enable are stable from 3 `clk` periods before to 3 after each `LDM_CLK` rising edge.
- **Latency.** With the first `clk` edge that samples `LDM_CLK` high as cycle 0, edge detect is in cycle 2. `row_sel`, `row_valid`, the pulses and `frame_cnt` update at cycle 3. Latency is fixed at 3 cycles.
- **Pulse width.** `frame_start` and `frame_done` are exactly one cycle. With ROWS = 1 not allowed, they never coincide.
- **Edge and timeout in the same cycle.** The edge wins: the counter clears, the edge is decoded, and there is no IDLE entry.
- **`rst` asserted mid-frame.** All outputs take their reset values at the next `clk` edge. The synchronizer contents are also cleared.

## Structure
- Package `ldm_pkg`: `LDM_ADDR_W` = 4, `LDM_ROWS_MAX` = 16, state enum (IDLE, SYNC, RUN), and default TIMEOUT.
- Sub-module `ldm_sync_edge`: 2-FF synchronizer plus rising-edge detector, parameterised by width. It is used once for `LDM_CLK` (edge output used) and once for the 5-bit {enable, address} bus (synchronized value only).
- The top level holds the FSM, `exp`, the timeout counter and the output registers.

## Test plan
- **Nominal scan.** Reset, then drive addresses 0..15 with enable high, 2 frames, `LDM_CLK` period 8 `clk`. Required:
  - `row_sel` steps 0x0001…0x8000, each 3 cycles after the edge.
  - `frame_start` pulses twice and `frame_done` twice.
  - `frame_cnt` = 2 and `seq_err` = 0.
- **Skip.** Send 0,1,2,4. Required: `seq_err` = 1 and `row_sel` = 0 at the address-4 edge + 3. A following 0,1 resyncs, giving `row_sel` = 0x0002 while `seq_err` stays 1.
- **Blanking.** Edge with enable low after row 5, then address 6 enabled. Required: `row_sel` = 0 and then 0x0040, with no `seq_err`.
- **Timeout.** Stop `LDM_CLK` for 1024 cycles. Required: `link_lost` = 1 and `row_sel` = 0. The next edge clears `link_lost`, and address 0 on the following edge gives `frame_start`.
- **Wrap and reset.** Run 256 frames and require `frame_cnt` = 0 after the 256th `frame_done`. Assert `rst` at row 9 and require all outputs 0 next cycle. A subsequent scan from 0 must decode normally.

Source files
------------

// File: rtl/ldm_pkg.sv
// -----------------------------------------------------------------------------
// ldm_pkg
// Shared constants and types for the LED dot-matrix scan receiver.
//   LDM_ADDR_W       width of the LDM_ADDR row-address bus
//   LDM_ROWS_MAX     largest row count the address bus can express
//   LDM_TIMEOUT_DEF  default clk cycles without a scan edge before link loss
//   ldm_state_e      receiver states: IDLE (link lost), SYNC (hunting for
//                    row 0), RUN (tracking the row sequence)
// -----------------------------------------------------------------------------
package ldm_pkg;

    localparam int LDM_ADDR_W      = 4;
    localparam int LDM_ROWS_MAX    = 16;
    localparam int LDM_TIMEOUT_DEF = 1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2
    } ldm_state_e;

endpackage : ldm_pkg

// File: rtl/ldm_sync_edge.sv
// -----------------------------------------------------------------------------
// ldm_sync_edge
// Two-flop synchronizer for a W-bit asynchronous input, followed by a
// registered rising-edge detector (stage 2 compared against one more delay
// flop). The edge output is registered so a scan edge is reported two cycles
// after the first clk edge that samples the input high.
//   clk     receiver clock
//   rst     synchronous active-high reset; clears every stage
//   d_i     asynchronous input bits
//   q_o     synchronized value (stage 2)
//   rise_o  one-cycle pulse per bit on a synchronized 0->1 transition
// -----------------------------------------------------------------------------
module ldm_sync_edge #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o,
    output logic [W-1:0] rise_o
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;
    logic [W-1:0] dly_q;
    logic [W-1:0] rise_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= '0;
            s2_q   <= '0;
            dly_q  <= '0;
            rise_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make every stage take its
            // predecessor's pre-edge value, which is what forms the chain.
            s1_q   <= d_i;
            s2_q   <= s1_q;
            dly_q  <= s2_q;
            rise_q <= s2_q & ~dly_q;
        end
    end

    assign q_o    = s2_q;
    assign rise_o = rise_q;

endmodule : ldm_sync_edge

// File: rtl/ldm_scan_rx.sv
// -----------------------------------------------------------------------------
// ldm_scan_rx
// Receive-side decoder for the LDM scan interface. Synchronizes the scan
// clock and the {enable, address} bus, checks that rows arrive in order and
// rebuilds a one-hot row select for the matrix driver.
//   clk          receiver clock
//   rst          synchronous active-high reset
//   LDM_CLK      scan clock, asynchronous to clk
//   LDM_ADDR_EN  address valid; low means blanking
//   LDM_ADDR     row address, stable around each LDM_CLK rising edge
//   row_sel      one-hot active row, zero when blanked / idle / resyncing
//   row_valid    high while row_sel is non-zero
//   frame_start  one-cycle pulse when row 0 is accepted
//   frame_done   one-cycle pulse when row ROWS-1 is accepted
//   frame_cnt    completed frames, modulo 256
//   seq_err      sticky sequence error, cleared only by rst
//   link_lost    high while idle after a scan-clock timeout
// -----------------------------------------------------------------------------
module ldm_scan_rx
    import ldm_pkg::*;
#(
    parameter int ROWS    = LDM_ROWS_MAX,
    parameter int TIMEOUT = LDM_TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  LDM_CLK,
    input  logic                  LDM_ADDR_EN,
    input  logic [LDM_ADDR_W-1:0] LDM_ADDR,
    output logic [ROWS-1:0]       row_sel,
    output logic                  row_valid,
    output logic                  frame_start,
    output logic                  frame_done,
    output logic [7:0]            frame_cnt,
    output logic                  seq_err,
    output logic                  link_lost
);

    localparam int                    TO_W      = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0]       TO_MAX    = TO_W'(TIMEOUT);
    localparam logic [LDM_ADDR_W-1:0] ADDR_LAST = LDM_ADDR_W'(ROWS - 1);

    // ---------------------------------------------------------------- capture
    logic [0:0]            scan_rise;
    logic [0:0]            scan_lvl_unused;
    logic [LDM_ADDR_W:0]   bus_s;
    logic [LDM_ADDR_W:0]   bus_rise_unused;
    logic                  scan_edge;
    logic                  addr_en;
    logic [LDM_ADDR_W-1:0] addr;

    ldm_sync_edge #(.W(1)) u_clk_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (LDM_CLK),
        .q_o    (scan_lvl_unused),
        .rise_o (scan_rise)
    );

    ldm_sync_edge #(.W(LDM_ADDR_W + 1)) u_bus_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    ({LDM_ADDR_EN, LDM_ADDR}),
        .q_o    (bus_s),
        .rise_o (bus_rise_unused)
    );

    assign scan_edge = scan_rise[0];
    assign addr_en   = bus_s[LDM_ADDR_W];
    assign addr      = bus_s[LDM_ADDR_W-1:0];

    // ---------------------------------------------------------------- state
    ldm_state_e            state_q,       state_d;
    logic [LDM_ADDR_W-1:0] exp_q,         exp_d;
    logic [TO_W-1:0]       to_cnt_q,      to_cnt_d;
    logic [ROWS-1:0]       row_sel_q,     row_sel_d;
    logic                  row_valid_q,   row_valid_d;
    logic                  frame_start_q, frame_start_d;
    logic                  frame_done_q,  frame_done_d;
    logic [7:0]            frame_cnt_q,   frame_cnt_d;
    logic                  seq_err_q,     seq_err_d;
    logic                  link_lost_q,   link_lost_d;
    logic                  accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_SYNC;
            exp_q         <= '0;
            to_cnt_q      <= '0;
            row_sel_q     <= '0;
            row_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_cnt_q   <= '0;
            seq_err_q     <= 1'b0;
            link_lost_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            exp_q         <= exp_d;
            to_cnt_q      <= to_cnt_d;
            row_sel_q     <= row_sel_d;
            row_valid_q   <= row_valid_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            frame_cnt_q   <= frame_cnt_d;
            seq_err_q     <= seq_err_d;
            link_lost_q   <= link_lost_d;
        end
    end

    always_comb begin
        // NOTE: every next-state value starts as a hold (or idle pulse) so no
        // branch below leaves a signal unassigned and infers a latch.
        state_d       = state_q;
        exp_d         = exp_q;
        row_sel_d     = row_sel_q;
        row_valid_d   = row_valid_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        seq_err_d     = seq_err_q;
        link_lost_d   = link_lost_q;
        accept        = 1'b0;

        if (scan_edge) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TO_MAX) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end else begin
            to_cnt_d = to_cnt_q;
        end

        if (scan_edge) begin
            // A decoded edge always beats a timeout in the same cycle.
            unique case (state_q)
                ST_IDLE: begin
                    // The wake-up edge only restores the link; it is not decoded.
                    state_d     = ST_SYNC;
                    link_lost_d = 1'b0;
                end
                ST_SYNC: begin
                    if (addr_en && addr == '0) begin
                        accept  = 1'b1;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // exp_q is always below ROWS, so an equality test also
                    // rejects out-of-range addresses.
                    if (addr_en && addr == exp_q) begin
                        accept = 1'b1;
                    end else if (addr_en) begin
                        seq_err_d = 1'b1;
                        state_d   = ST_SYNC;
                        row_sel_d   = '0;
                        row_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_SYNC;
                end
            endcase

            if (!addr_en) begin
                row_sel_d   = '0;
                row_valid_d = 1'b0;
            end

            if (accept) begin
                row_sel_d     = ROWS'(1) << addr;
                row_valid_d   = 1'b1;
                frame_start_d = (addr == '0);
                exp_d         = (addr == ADDR_LAST) ? '0 : addr + LDM_ADDR_W'(1);
                if (addr == ADDR_LAST) begin
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 8'd1;
                end
            end
        end else if (to_cnt_q == TO_MAX) begin
            state_d     = ST_IDLE;
            link_lost_d = 1'b1;
            row_sel_d   = '0;
            row_valid_d = 1'b0;
        end
    end

    assign row_sel     = row_sel_q;
    assign row_valid   = row_valid_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign frame_cnt   = frame_cnt_q;
    assign seq_err     = seq_err_q;
    assign link_lost   = link_lost_q;

endmodule : ldm_scan_rx

// File: tb/tb_ldm_scan_rx.sv
// -----------------------------------------------------------------------------
// tb_ldm_scan_rx
// Self-checking bench for ldm_scan_rx. Scan edges are driven at 8 clk per
// LDM_CLK period; an event-level model predicts the decoded row, pulses,
// frame count and error/link flags for every edge.
// -----------------------------------------------------------------------------
module tb_ldm_scan_rx;

    localparam int ROWS    = 16;
    localparam int TIMEOUT = 1024;

    logic            clk = 1'b0;
    logic            rst;
    logic            LDM_CLK;
    logic            LDM_ADDR_EN;
    logic [3:0]      LDM_ADDR;
    logic [ROWS-1:0] row_sel;
    logic            row_valid;
    logic            frame_start;
    logic            frame_done;
    logic [7:0]      frame_cnt;
    logic            seq_err;
    logic            link_lost;

    int n_tests = 0;
    int n_fail  = 0;

    // Event-level reference model: one update per scan edge.
    bit m_synced;
    bit m_idle;
    bit m_err;
    int m_exp;
    int m_row;   // -1 means blanked
    int m_cnt;

    int obs_starts;
    int obs_dones;

    ldm_scan_rx #(.ROWS(ROWS), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .LDM_CLK     (LDM_CLK),
        .LDM_ADDR_EN (LDM_ADDR_EN),
        .LDM_ADDR    (LDM_ADDR),
        .row_sel     (row_sel),
        .row_valid   (row_valid),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .frame_cnt   (frame_cnt),
        .seq_err     (seq_err),
        .link_lost   (link_lost)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [ROWS-1:0] onehot(input int r);
        logic [ROWS-1:0] one;
        one = 1;
        return (r < 0) ? '0 : (one << r);
    endfunction

    task automatic model_reset();
        m_synced = 1'b0;
        m_idle   = 1'b0;
        m_err    = 1'b0;
        m_exp    = 0;
        m_row    = -1;
        m_cnt    = 0;
    endtask

    task automatic model_edge(input bit en, input int a, output bit e_start, output bit e_done);
        e_start = 1'b0;
        e_done  = 1'b0;
        if (m_idle) begin
            m_idle   = 1'b0;
            m_synced = 1'b0;
            m_row    = -1;
        end else if (!en) begin
            m_row = -1;
        end else if ((!m_synced && a == 0) || (m_synced && a == m_exp)) begin
            m_synced = 1'b1;
            m_row    = a;
            m_exp    = (a + 1) % ROWS;
            e_start  = (a == 0);
            if (a == ROWS - 1) begin
                e_done = 1'b1;
                m_cnt  = (m_cnt + 1) % 256;
            end
        end else if (m_synced) begin
            m_err    = 1'b1;
            m_synced = 1'b0;
            m_row    = -1;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst         = 1'b1;
        LDM_CLK     = 1'b0;
        LDM_ADDR_EN = 1'b0;
        LDM_ADDR    = 4'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One LDM_CLK period (3 clk low, 5 clk high) carrying one address.
    // Outputs must be unchanged at edge+2 and show the decode at edge+3.
    task automatic do_edge(input string name, input bit en, input int a);
        logic [ROWS-1:0] prev_sel;
        logic [ROWS-1:0] exp_sel;
        logic            exp_valid;
        bit              e_start;
        bit              e_done;
        prev_sel = onehot(m_row);
        @(negedge clk);
        LDM_CLK     = 1'b0;
        LDM_ADDR_EN = en;
        LDM_ADDR    = a[3:0];
        repeat (3) @(negedge clk);
        LDM_CLK = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (row_sel !== prev_sel || frame_start !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s early(addr=%0d): row_sel=%h start=%b done=%b, required row_sel=%h start=0 done=0",
                     name, a, row_sel, frame_start, frame_done, prev_sel);
        end
        model_edge(en, a, e_start, e_done);
        exp_sel   = onehot(m_row);
        exp_valid = (m_row >= 0);
        @(posedge clk);
        #1;
        if (frame_start === 1'b1) obs_starts++;
        if (frame_done === 1'b1) obs_dones++;
        n_tests++;
        if (row_sel !== exp_sel || row_valid !== exp_valid) begin
            n_fail++;
            $display("FAIL %s row(en=%0b addr=%0d): row_sel=%h valid=%b, required row_sel=%h valid=%b",
                     name, en, a, row_sel, row_valid, exp_sel, exp_valid);
        end
        n_tests++;
        if (frame_start !== e_start || frame_done !== e_done) begin
            n_fail++;
            $display("FAIL %s pulse(addr=%0d): start=%b done=%b, required start=%b done=%b",
                     name, a, frame_start, frame_done, e_start, e_done);
        end
        n_tests++;
        if (frame_cnt !== 8'(m_cnt) || seq_err !== m_err || link_lost !== m_idle) begin
            n_fail++;
            $display("FAIL %s flags(addr=%0d): cnt=%0d err=%b lost=%b, required cnt=%0d err=%b lost=%b",
                     name, a, frame_cnt, seq_err, link_lost, m_cnt, m_err, m_idle);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (frame_start !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s pulse_width(addr=%0d): start=%b done=%b, required 0 0",
                     name, a, frame_start, frame_done);
        end
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        LDM_CLK     = 1'b0;
        LDM_ADDR_EN = 1'b0;
        LDM_ADDR    = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (row_sel !== '0 || row_valid !== 1'b0 || frame_start !== 1'b0 || frame_done !== 1'b0 ||
            frame_cnt !== 8'd0 || seq_err !== 1'b0 || link_lost !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: row_sel=%h valid=%b start=%b done=%b cnt=%0d err=%b lost=%b, required all 0",
                     row_sel, row_valid, frame_start, frame_done, frame_cnt, seq_err, link_lost);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (4) @(posedge clk);
        #1;
        n_tests++;
        if (row_sel !== '0 || row_valid !== 1'b0 || link_lost !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: row_sel=%h valid=%b lost=%b, required 0 0 0", row_sel, row_valid, link_lost);
        end
    endtask

    task automatic test_nominal();
        apply_reset();
        obs_starts = 0;
        obs_dones  = 0;
        for (int f = 0; f < 2; f++) begin
            for (int a = 0; a < ROWS; a++) do_edge("nominal", 1'b1, a);
        end
        n_tests++;
        if (obs_starts != 2 || obs_dones != 2) begin
            n_fail++;
            $display("FAIL nominal_pulses: starts=%0d dones=%0d, required 2 2", obs_starts, obs_dones);
        end
        n_tests++;
        if (frame_cnt !== 8'd2 || seq_err !== 1'b0 || row_sel !== 16'h8000) begin
            n_fail++;
            $display("FAIL nominal_end: cnt=%0d err=%b row_sel=%h, required 2 0 8000", frame_cnt, seq_err, row_sel);
        end
    endtask

    task automatic test_skip();
        apply_reset();
        do_edge("skip", 1'b1, 0);
        do_edge("skip", 1'b1, 1);
        do_edge("skip", 1'b1, 2);
        do_edge("skip", 1'b1, 4);
        n_tests++;
        if (seq_err !== 1'b1 || row_sel !== 16'h0000) begin
            n_fail++;
            $display("FAIL skip_error: err=%b row_sel=%h, required 1 0000", seq_err, row_sel);
        end
        do_edge("skip_resync", 1'b1, 0);
        do_edge("skip_resync", 1'b1, 1);
        n_tests++;
        if (seq_err !== 1'b1 || row_sel !== 16'h0002) begin
            n_fail++;
            $display("FAIL skip_resync: err=%b row_sel=%h, required 1 0002", seq_err, row_sel);
        end
    endtask

    task automatic test_blanking();
        apply_reset();
        for (int a = 0; a <= 5; a++) do_edge("blank", 1'b1, a);
        do_edge("blank", 1'b0, 9);
        n_tests++;
        if (row_sel !== 16'h0000 || row_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL blank_gap: row_sel=%h valid=%b, required 0000 0", row_sel, row_valid);
        end
        do_edge("blank", 1'b1, 6);
        n_tests++;
        if (row_sel !== 16'h0040 || seq_err !== 1'b0) begin
            n_fail++;
            $display("FAIL blank_resume: row_sel=%h err=%b, required 0040 0", row_sel, seq_err);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        for (int a = 0; a <= 3; a++) do_edge("timeout", 1'b1, a);
        // Counter clears at edge+3 and reaches TIMEOUT TIMEOUT cycles later;
        // link_lost follows one cycle after that.
        repeat (TIMEOUT - 1) @(posedge clk);
        #1;
        n_tests++;
        if (link_lost !== 1'b0 || row_sel !== 16'h0008) begin
            n_fail++;
            $display("FAIL timeout_early: lost=%b row_sel=%h, required 0 0008", link_lost, row_sel);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (link_lost !== 1'b1 || row_sel !== 16'h0000 || row_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_lost: lost=%b row_sel=%h valid=%b, required 1 0000 0", link_lost, row_sel, row_valid);
        end
        m_idle = 1'b1;
        m_row  = -1;
        obs_starts = 0;
        do_edge("timeout_wake", 1'b1, 0);
        n_tests++;
        if (link_lost !== 1'b0 || obs_starts != 0) begin
            n_fail++;
            $display("FAIL timeout_wake: lost=%b starts=%0d, required 0 0", link_lost, obs_starts);
        end
        do_edge("timeout_resume", 1'b1, 0);
        n_tests++;
        if (obs_starts != 1 || row_sel !== 16'h0001) begin
            n_fail++;
            $display("FAIL timeout_resume: starts=%0d row_sel=%h, required 1 0001", obs_starts, row_sel);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 150; i++) begin
            int r;
            int a;
            bit en;
            r  = $urandom_range(0, 9);
            en = (r != 0);
            if (r == 1) a = $urandom_range(0, ROWS - 1);
            else        a = m_synced ? m_exp : 0;
            do_edge("random", en, a);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int f = 0; f < 256; f++) begin
            for (int a = 0; a < ROWS; a++) do_edge("wrap", 1'b1, a);
            if (f == 254) begin
                n_tests++;
                if (frame_cnt !== 8'd255) begin
                    n_fail++;
                    $display("FAIL wrap_255: cnt=%0d, required 255", frame_cnt);
                end
            end
        end
        n_tests++;
        if (frame_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL wrap_zero: cnt=%0d, required 0", frame_cnt);
        end
    endtask

    task automatic test_reset_midframe();
        apply_reset();
        for (int a = 0; a < ROWS; a++) do_edge("midrst_pre", 1'b1, a);
        do_edge("midrst_pre", 1'b1, 0);
        do_edge("midrst_pre", 1'b1, 1);
        do_edge("midrst_pre", 1'b1, 3);
        for (int a = 0; a <= 9; a++) do_edge("midrst_pre", 1'b1, a);
        @(negedge clk);
        rst     = 1'b1;
        LDM_CLK = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (row_sel !== '0 || row_valid !== 1'b0 || frame_start !== 1'b0 || frame_done !== 1'b0 ||
            frame_cnt !== 8'd0 || seq_err !== 1'b0 || link_lost !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_reset: row_sel=%h valid=%b cnt=%0d err=%b lost=%b, required all 0",
                     row_sel, row_valid, frame_cnt, seq_err, link_lost);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        obs_starts = 0;
        obs_dones  = 0;
        for (int a = 0; a < ROWS; a++) do_edge("midrst_post", 1'b1, a);
        n_tests++;
        if (frame_cnt !== 8'd1 || seq_err !== 1'b0 || obs_starts != 1 || obs_dones != 1) begin
            n_fail++;
            $display("FAIL midframe_rescan: cnt=%0d err=%b starts=%0d dones=%0d, required 1 0 1 1",
                     frame_cnt, seq_err, obs_starts, obs_dones);
        end
    endtask

    initial begin
        model_reset();
        obs_starts = 0;
        obs_dones  = 0;
        test_reset();
        test_nominal();
        test_skip();
        test_blanking();
        test_timeout();
        test_random();
        test_wrap();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ldm_scan_rx
